// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI address sequencer: takes one AW/AR descriptor and walks it
// beat by beat (FIXED/INCR/WRAP), flagging protocol violations per burst.
//
// Ports: clk_i/rst_i (async active-high), req_* descriptor handshake,
//        beat_* per-beat descriptor handshake (addr, lane, idx, last, id, err).

package axi_math_pkg;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

module axi_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 4,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int LANE_W    = axi_math_pkg::idx_width(STRB_W)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  input  logic [2:0]            req_size_i,
  input  logic [1:0]            req_burst_i,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic [ADDR_WIDTH-1:0] beat_addr_o,
  output logic [LANE_W-1:0]     beat_lane_o,
  output logic [LEN_WIDTH-1:0]  beat_idx_o,
  output logic                  beat_last_o,
  output logic [ID_WIDTH-1:0]   beat_id_o,
  output logic                  beat_err_o
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_W));

  // Wide enough for (len+1)<<7 and for address carry-out.
  localparam int XW =
    ((ADDR_WIDTH > LEN_WIDTH + 8) ? ADDR_WIDTH : LEN_WIDTH + 8) + 1;

  localparam logic [1:0] B_FIXED = 2'd0;
  localparam logic [1:0] B_INCR  = 2'd1;
  localparam logic [1:0] B_WRAP  = 2'd2;
  localparam logic [1:0] B_RSVD  = 2'd3;

  typedef enum logic [0:0] {
    IDLE,
    BURST
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  idx_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [2:0]            size_q;
  logic [1:0]            mode_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  err_q;

  logic accept;
  logic advance;

  // Beat-to-beat address stepping
  logic [XW-1:0]         step;
  logic [XW-1:0]         smask;
  logic [XW-1:0]         wmask;
  logic [XW-1:0]         cur;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  always_comb begin
    step  = XW'(1) << size_q;
    smask = step - XW'(1);
    wmask = ((XW'(len_q) + XW'(1)) << size_q) - XW'(1);
    cur   = XW'(addr_q);
    unique case (mode_q)
      B_FIXED: addr_nxt = addr_q;
      B_WRAP:  addr_nxt = ADDR_WIDTH'((cur & ~wmask) |
                                      ((cur + step) & wmask));
      default: addr_nxt = ADDR_WIDTH'((cur & ~smask) + step);
    endcase
  end

  // Descriptor checks, evaluated on the incoming request
  logic [XW-1:0]         r_step;
  logic [XW-1:0]         r_smask;
  logic [XW-1:0]         r_wlen;
  logic [XW-1:0]         r_cur;
  logic [ADDR_WIDTH-1:0] r_last;
  logic                  wrap_len_ok;
  logic                  wrap_bad;
  logic                  cross_4k;
  logic                  err_d;
  logic [1:0]            mode_d;

  always_comb begin
    r_step  = XW'(1) << req_size_i;
    r_smask = r_step - XW'(1);
    r_wlen  = (XW'(req_len_i) + XW'(1)) << req_size_i;
    r_cur   = XW'(req_addr_i);
    r_last  = ADDR_WIDTH'((r_cur & ~r_smask) + r_wlen - XW'(1));
    wrap_len_ok = (req_len_i == LEN_WIDTH'(1)) |
                  (req_len_i == LEN_WIDTH'(3)) |
                  (req_len_i == LEN_WIDTH'(7)) |
                  (req_len_i == LEN_WIDTH'(15));
    wrap_bad = (req_burst_i == B_WRAP) &
               (!wrap_len_ok | ((r_cur & r_smask) != '0));
    cross_4k = (req_burst_i == B_INCR) &
               ((r_last >> 12) != (req_addr_i >> 12));
    err_d = (req_size_i > MAX_SIZE) |
            (req_burst_i == B_RSVD) |
            wrap_bad | cross_4k;
    // Reserved and malformed WRAP bursts still get a sane INCR walk.
    mode_d = ((req_burst_i == B_RSVD) | wrap_bad) ? B_INCR : req_burst_i;
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    beat_valid_o = 1'b0;
    beat_last_o  = 1'b0;
    advance      = 1'b0;
    unique case (state_q)
      IDLE: req_ready_o = !rst_i;
      BURST: begin
        beat_valid_o = 1'b1;
        beat_last_o  = (idx_q == len_q);
        if (beat_ready_i & beat_last_o) begin
          req_ready_o = !rst_i;
          state_d     = IDLE;
        end else if (beat_ready_i) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    accept = req_valid_i & req_ready_o;
    if (accept) state_d = BURST;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      mode_q  <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= req_addr_i;
        idx_q  <= '0;
        len_q  <= req_len_i;
        size_q <= req_size_i;
        mode_q <= mode_d;
        id_q   <= req_id_i;
        err_q  <= err_d;
      end else if (advance) begin
        addr_q <= addr_nxt;
        idx_q  <= idx_q + LEN_WIDTH'(1);
      end
    end
  end

  assign beat_addr_o = addr_q;
  assign beat_lane_o = addr_q[LANE_W-1:0];
  assign beat_idx_o  = idx_q;
  assign beat_id_o   = id_q;
  assign beat_err_o  = err_q;

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed testbench for axi_burst_addr_gen (default parameters,
// DATA_WIDTH=64): reset, burst types, errors, back-to-back, mid-burst reset.

module tb_axi_burst_addr_gen;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic [3:0]  req_id;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [2:0]  beat_lane;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic [3:0]  beat_id;
  logic        beat_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] got_addr [0:31];
  logic [2:0]  got_lane [0:31];
  logic [7:0]  got_idx  [0:31];
  logic        got_last [0:31];
  logic        got_err  [0:31];
  int          n_got;
  logic        lat_ok;

  axi_burst_addr_gen dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_len_i    (req_len),
    .req_size_i   (req_size),
    .req_burst_i  (req_burst),
    .req_id_i     (req_id),
    .beat_valid_o (beat_valid),
    .beat_ready_i (beat_ready),
    .beat_addr_o  (beat_addr),
    .beat_lane_o  (beat_lane),
    .beat_idx_o   (beat_idx),
    .beat_last_o  (beat_last),
    .beat_id_o    (beat_id),
    .beat_err_o   (beat_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Drives one descriptor with beat_ready held high and records every beat.
  task automatic run_burst(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b,
                           input logic [3:0] id);
    int  k;
    bit  done;
    n_got  = 0;
    lat_ok = 1'b0;
    beat_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    req_size  = s;
    req_burst = b;
    req_id    = id;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout got ready=%b exp 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    lat_ok = beat_valid;
    k = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      if (beat_valid && n_got < 32) begin
        got_addr[n_got] = beat_addr;
        got_lane[n_got] = beat_lane;
        got_idx[n_got]  = beat_idx;
        got_last[n_got] = beat_last;
        got_err[n_got]  = beat_err;
        n_got++;
        if (beat_last) done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) @(negedge clk);
      k++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout got %0d beats exp last", n_got);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    tests++;
    if (beat_valid !== 1'b0 || req_ready !== 1'b0 || beat_last !== 1'b0 ||
        beat_err !== 1'b0 || beat_addr !== 32'h0 || beat_idx !== 8'h0 ||
        beat_id !== 4'h0) begin
      fails++;
      $display("FAIL reset_state got v=%b r=%b l=%b e=%b a=%h i=%h id=%h exp all 0",
               beat_valid, req_ready, beat_last, beat_err,
               beat_addr, beat_idx, beat_id);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_incr_aligned;
    logic [31:0] ea [0:3];
    ea = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
    run_burst(32'h1004, 8'd3, 3'd2, 2'd1, 4'h3);
    tests++;
    if (lat_ok !== 1'b1) begin
      fails++;
      $display("FAIL incr_latency got valid=%b exp 1", lat_ok);
    end
    tests++;
    if (n_got != 4) begin
      fails++;
      $display("FAIL incr_count got %0d exp 4", n_got);
    end
    for (int i = 0; i < 4 && i < n_got; i++) begin
      tests++;
      if (got_addr[i] !== ea[i] || got_idx[i] !== 8'(i) ||
          got_last[i] !== (i == 3) || got_err[i] !== 1'b0) begin
        fails++;
        $display("FAIL incr_beat%0d got a=%h i=%0d l=%b e=%b exp a=%h i=%0d l=%b e=0",
                 i, got_addr[i], got_idx[i], got_last[i], got_err[i],
                 ea[i], i, (i == 3));
      end
    end
  endtask

  task automatic test_incr_unaligned;
    logic [31:0] ea [0:2];
    logic [2:0]  el [0:2];
    ea = '{32'h1003, 32'h1004, 32'h1008};
    el = '{3'd3, 3'd4, 3'd0};
    run_burst(32'h1003, 8'd2, 3'd2, 2'd1, 4'h1);
    tests++;
    if (n_got != 3) begin
      fails++;
      $display("FAIL unal_count got %0d exp 3", n_got);
    end
    for (int i = 0; i < 3 && i < n_got; i++) begin
      tests++;
      if (got_addr[i] !== ea[i] || got_lane[i] !== el[i] ||
          got_err[i] !== 1'b0) begin
        fails++;
        $display("FAIL unal_beat%0d got a=%h lane=%0d e=%b exp a=%h lane=%0d e=0",
                 i, got_addr[i], got_lane[i], got_err[i], ea[i], el[i]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [31:0] ea [0:3];
    ea = '{32'h38, 32'h20, 32'h28, 32'h30};
    run_burst(32'h38, 8'd3, 3'd3, 2'd2, 4'h2);
    tests++;
    if (n_got != 4) begin
      fails++;
      $display("FAIL wrap_count got %0d exp 4", n_got);
    end
    for (int i = 0; i < 4 && i < n_got; i++) begin
      tests++;
      if (got_addr[i] !== ea[i] || got_err[i] !== 1'b0 ||
          got_last[i] !== (i == 3)) begin
        fails++;
        $display("FAIL wrap_beat%0d got a=%h e=%b l=%b exp a=%h e=0 l=%b",
                 i, got_addr[i], got_err[i], got_last[i], ea[i], (i == 3));
      end
    end
  endtask

  task automatic test_fixed_len0;
    run_burst(32'h500, 8'd2, 3'd3, 2'd0, 4'h4);
    tests++;
    if (n_got != 3) begin
      fails++;
      $display("FAIL fixed_count got %0d exp 3", n_got);
    end
    for (int i = 0; i < 3 && i < n_got; i++) begin
      tests++;
      if (got_addr[i] !== 32'h500 || got_idx[i] !== 8'(i)) begin
        fails++;
        $display("FAIL fixed_beat%0d got a=%h i=%0d exp a=500 i=%0d",
                 i, got_addr[i], got_idx[i], i);
      end
    end
    run_burst(32'h40, 8'd0, 3'd3, 2'd1, 4'h5);
    tests++;
    if (n_got != 1 || got_last[0] !== 1'b1 || got_addr[0] !== 32'h40) begin
      fails++;
      $display("FAIL len0 got n=%0d l=%b a=%h exp n=1 l=1 a=40",
               n_got, got_last[0], got_addr[0]);
    end
  endtask

  task automatic test_errors;
    // 4KB crossing
    run_burst(32'hFF8, 8'd1, 3'd3, 2'd1, 4'h6);
    tests++;
    if (n_got != 2 || got_addr[0] !== 32'hFF8 || got_addr[1] !== 32'h1000 ||
        got_err[0] !== 1'b1 || got_err[1] !== 1'b1) begin
      fails++;
      $display("FAIL err_4k got n=%0d a0=%h a1=%h e=%b%b exp n=2 a0=ff8 a1=1000 e=11",
               n_got, got_addr[0], got_addr[1], got_err[0], got_err[1]);
    end
    // WRAP len=2 walks as INCR
    run_burst(32'h100, 8'd2, 3'd2, 2'd2, 4'h7);
    tests++;
    if (n_got != 3 || got_addr[1] !== 32'h104 || got_addr[2] !== 32'h108 ||
        got_err[0] !== 1'b1 || got_err[2] !== 1'b1) begin
      fails++;
      $display("FAIL err_wraplen got n=%0d a1=%h a2=%h e=%b%b exp n=3 a1=104 a2=108 e=11",
               n_got, got_addr[1], got_addr[2], got_err[0], got_err[2]);
    end
    // oversize at 64-bit data
    run_burst(32'h0, 8'd1, 3'd4, 2'd1, 4'h8);
    tests++;
    if (n_got != 2 || got_addr[1] !== 32'h10 || got_err[0] !== 1'b1 ||
        got_err[1] !== 1'b1) begin
      fails++;
      $display("FAIL err_size got n=%0d a1=%h e=%b%b exp n=2 a1=10 e=11",
               n_got, got_addr[1], got_err[0], got_err[1]);
    end
    // misaligned WRAP
    run_burst(32'h102, 8'd1, 3'd2, 2'd2, 4'h9);
    tests++;
    if (n_got != 2 || got_addr[1] !== 32'h104 || got_err[0] !== 1'b1) begin
      fails++;
      $display("FAIL err_wrapalign got n=%0d a1=%h e=%b exp n=2 a1=104 e=1",
               n_got, got_addr[1], got_err[0]);
    end
    // reserved burst type
    run_burst(32'h200, 8'd1, 3'd2, 2'd3, 4'hA);
    tests++;
    if (n_got != 2 || got_addr[1] !== 32'h204 || got_err[1] !== 1'b1) begin
      fails++;
      $display("FAIL err_rsvd got n=%0d a1=%h e=%b exp n=2 a1=204 e=1",
               n_got, got_addr[1], got_err[1]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ea [0:6];
    logic [3:0]  ei [0:6];
    logic        el [0:6];
    logic        rp [0:7];
    ea = '{32'h2000, 32'h2004, 32'h2004, 32'h3000,
           32'h3000, 32'h3004, 32'h3004};
    ei = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2};
    el = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    beat_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h2000;
    req_len    = 8'd1;
    req_size   = 3'd2;
    req_burst  = 2'd1;
    req_id     = 4'h1;
    @(posedge clk);
    #1;
    req_addr   = 32'h3000;
    req_id     = 4'h2;
    beat_ready = rp[0];
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      tests++;
      if (beat_valid !== 1'b1 || beat_addr !== ea[i] ||
          beat_id !== ei[i] || beat_last !== el[i]) begin
        fails++;
        $display("FAIL b2b_cyc%0d got v=%b a=%h id=%h l=%b exp v=1 a=%h id=%h l=%b",
                 i, beat_valid, beat_addr, beat_id, beat_last,
                 ea[i], ei[i], el[i]);
      end
      if (i == 1 || i == 2) begin
        tests++;
        if (req_ready !== (i == 2)) begin
          fails++;
          $display("FAIL b2b_ready_cyc%0d got %b exp %b",
                   i, req_ready, (i == 2));
        end
      end
      @(posedge clk);
      #1;
      beat_ready = rp[i+1];
      if (i == 2) req_valid = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (beat_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle got v=%b r=%b exp v=0 r=1",
               beat_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    beat_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h4000;
    req_len   = 8'd7;
    req_size  = 3'd2;
    req_burst = 2'd1;
    req_id    = 4'hB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (beat_valid !== 1'b1 || beat_idx !== 8'd2 ||
        beat_addr !== 32'h4008) begin
      fails++;
      $display("FAIL mid_pre got v=%b i=%0d a=%h exp v=1 i=2 a=4008",
               beat_valid, beat_idx, beat_addr);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (beat_valid !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_async got v=%b r=%b exp v=0 r=0",
               beat_valid, req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (beat_valid !== 1'b0 || req_ready !== 1'b1) begin
        fails++;
        $display("FAIL mid_after%0d got v=%b r=%b exp v=0 r=1",
                 i, beat_valid, req_ready);
      end
    end
  endtask

  initial begin
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    req_size   = '0;
    req_burst  = '0;
    req_id     = '0;
    beat_ready = 1'b0;
    test_reset;
    test_incr_aligned;
    test_incr_unaligned;
    test_wrap;
    test_fixed_len0;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
